// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundle of the fetch port, the load/store port and the byte-wide memory port.
//   slave  modport: arbiter view (requests in, grants/read word/memory strobes out)
//   master modport: environment view (drives requests and memory responses)
interface riscv_mem_arbiter_if #(parameter int ADDR_W = 16);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic [31:0]       rdata;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              busy;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_gnt, d_gnt, rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_gnt, d_gnt, rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: serialises fetch and load/store word accesses onto a byte-wide memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : if_req/if_addr/if_gnt, d_req/d_we/d_addr/d_wdata/d_gnt, shared rdata,
//                mem_valid/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready, busy
module riscv_mem_arbiter #(parameter int ADDR_W = 16) (
  input logic                  clk,
  input logic                  rst_n,
  riscv_mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pick_d;
  logic              if_gnt, d_gnt, mem_valid, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [31:0]       rdata;
  // owner/last encoding: 1 = data port, 0 = fetch port; a tie goes to whoever was not served last
  assign pick_d = bus.d_req & (~bus.if_req | ~last_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    rdata     = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (bus.if_req | bus.d_req) begin
        owner_d = pick_d;
        base_d  = (pick_d ? bus.d_addr : bus.if_addr) & ~ADDR_W'(3);
        we_d    = pick_d & bus.d_we;
        wdata_d = pick_d ? bus.d_wdata : '0;
        cnt_d   = '0;
        rdata_d = '0;
        state_d = XFER;
      end
      XFER: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + ADDR_W'(cnt_q);
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        if (bus.mem_ready) begin
          if (!we_q) rdata_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
          if (cnt_q == 2'd3) state_d = DONE;
          else cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if_gnt  = ~owner_q;
        d_gnt   = owner_q;
        rdata   = rdata_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.rdata     = rdata;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench for riscv_mem_arbiter with a byte memory model.
module tb_riscv_mem_arbiter;
  typedef struct { logic [15:0] addr; logic we; logic [7:0] wdata; } byte_t;
  typedef struct { logic is_d; logic [31:0] rdata; } gnt_t;
  logic clk, rst_n;
  logic [7:0] mem [0:65535];
  byte_t bq[$];
  gnt_t gq[$];
  byte_t b;
  gnt_t g;
  int errors = 0;
  int checks = 0;
  int stall_left = 0;
  riscv_mem_arbiter_if #(.ADDR_W(16)) bus();
  riscv_mem_arbiter #(.ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk)
    if (rst_n && bus.mem_valid && bus.mem_ready && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_txn(logic is_d, logic we, logic [15:0] addr, logic [31:0] wd);
    logic [15:0] base;
    logic [31:0] rd;
    byte_t e;
    gnt_t t;
    base = addr & 16'hFFFC;
    rd = '0;
    for (int i = 0; i < 4; i++) begin
      e.addr = base + 16'(i);
      e.we = we;
      e.wdata = wd[8*i +: 8];
      bq.push_back(e);
      if (!we) rd[8*i +: 8] = mem[e.addr];
    end
    t.is_d = is_d;
    t.rdata = rd;
    gq.push_back(t);
  endtask
  task automatic wait_gnt(logic is_d, int lat, string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? bus.d_gnt : bus.if_gnt) && n < 40);
    chk(tag, 64'(n), 64'(lat));
  endtask
  task automatic run(logic is_d, logic we, logic [15:0] addr, logic [31:0] wd, int lat, string tag);
    @(negedge clk);
    push_txn(is_d, we, addr, wd);
    if (is_d) begin
      bus.d_we = we;
      bus.d_addr = addr;
      bus.d_wdata = wd;
      bus.d_req = 1'b1;
    end else begin
      bus.if_addr = addr;
      bus.if_req = 1'b1;
    end
    wait_gnt(is_d, lat, tag);
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
  endtask
  always @(negedge clk) begin
    bus.mem_ready = !(bus.mem_valid && bus.mem_addr[1:0] == 2'd2 && stall_left > 0);
    if (!bus.mem_ready) stall_left--;
    if (rst_n) begin
      if (!bus.mem_valid) chk("idle_bus", 64'({bus.mem_we, bus.mem_wdata}), 64'(0));
      else if (bq.size() == 0) chk("byte_extra", 64'(bq.size()), 64'(1));
      else begin
        b = bq[0];
        chk("mem_addr", 64'(bus.mem_addr), 64'(b.addr));
        chk("mem_we", 64'(bus.mem_we), 64'(b.we));
        if (b.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
        if (bus.mem_ready) void'(bq.pop_front());
      end
      if (bus.if_gnt || bus.d_gnt) begin
        chk("gnt_excl", 64'(bus.if_gnt & bus.d_gnt), 64'(0));
        if (gq.size() == 0) chk("gnt_extra", 64'(gq.size()), 64'(1));
        else begin
          g = gq.pop_front();
          chk("gnt_owner", 64'(bus.d_gnt), 64'(g.is_d));
          chk("rdata", 64'(bus.rdata), 64'(g.rdata));
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0100] = 8'h13;
    mem[16'h0101] = 8'h05;
    mem[16'h0102] = 8'h10;
    mem[16'h0103] = 8'h00;
    rst_n = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({bus.busy, bus.mem_valid, bus.mem_we, bus.if_gnt, bus.d_gnt}), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    rst_n = 1'b1;
    push_txn(1'b1, 1'b0, 16'h0080, 32'h0);
    push_txn(1'b0, 1'b0, 16'h0040, 32'h0);
    push_txn(1'b1, 1'b0, 16'h0080, 32'h0);
    bus.if_addr = 16'h0040;
    bus.d_addr = 16'h0080;
    bus.d_we = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    wait_gnt(1'b1, 5, "tie_first_data");
    wait_gnt(1'b0, 6, "tie_then_fetch");
    bus.if_req = 1'b0;
    wait_gnt(1'b1, 6, "tie_data_again");
    bus.d_req = 1'b0;
    run(1'b0, 1'b0, 16'h0102, 32'h0, 5, "lat_fetch");
    chk("fetch_word", 64'(bus.rdata), 64'(32'h00100513));
    run(1'b1, 1'b1, 16'h0FFE, 32'hDEADBEEF, 5, "lat_store");
    chk("store_rdata", 64'(bus.rdata), 64'(0));
    chk("store_mem", 64'({mem[16'h0FFF], mem[16'h0FFE], mem[16'h0FFD], mem[16'h0FFC]}), 64'(32'hDEADBEEF));
    run(1'b1, 1'b0, 16'h0FFC, 32'h0, 5, "lat_load");
    chk("load_back", 64'(bus.rdata), 64'(32'hDEADBEEF));
    stall_left = 3;
    run(1'b0, 1'b0, 16'h0100, 32'h0, 8, "lat_wait_fetch");
    chk("wait_word", 64'(bus.rdata), 64'(32'h00100513));
    stall_left = 3;
    run(1'b1, 1'b1, 16'h2001, 32'h11223344, 8, "lat_wait_store");
    chk("wait_store_mem", 64'({mem[16'h2003], mem[16'h2002], mem[16'h2001], mem[16'h2000]}), 64'(32'h11223344));
    run(1'b0, 1'b0, 16'hFFFE, 32'h0, 5, "lat_top");
    @(negedge clk);
    push_txn(1'b0, 1'b0, 16'h0200, 32'h0);
    bus.if_addr = 16'h0200;
    bus.if_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_valid && bus.mem_addr == 16'h0201) && n < 20);
    chk("reach_byte1", 64'(bus.mem_addr), 64'(16'h0201));
    #2 rst_n = 1'b0;
    bus.if_req = 1'b0;
    #1;
    chk("rst_mid_outs", 64'({bus.busy, bus.mem_valid, bus.if_gnt, bus.d_gnt}), 64'(0));
    bq.delete();
    gq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_txn(1'b0, 1'b0, 16'h0300, 32'h0);
    bus.if_addr = 16'h0300;
    bus.if_req = 1'b1;
    wait_gnt(1'b0, 5, "lat_after_rst");
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("gq_empty", 64'(gq.size()), 64'(0));
    chk("bq_empty", 64'(bq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
